// File: rtl/sel_encoder_16x4_pkg.sv
// Shared definitions for the 16-to-4 select encoder.
// Contents:
//   state_t          - output-holding FSM states
//   ERR_SEL          - mux select driven in error mode / for unmapped channels
//   SEL_CH0..SEL_CH5 - mux select codes for data channels 0..5
package sel_encoder_16x4_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    ERROR = 2'd2
  } state_t;

  localparam logic [4:0] ERR_SEL = 5'b11111;

  // Channel 0 is the all-zero select; channels 1..5 each own one select bit.
  localparam logic [4:0] SEL_CH0 = 5'b00000;
  localparam logic [4:0] SEL_CH1 = 5'b00001;
  localparam logic [4:0] SEL_CH2 = 5'b00010;
  localparam logic [4:0] SEL_CH3 = 5'b00100;
  localparam logic [4:0] SEL_CH4 = 5'b01000;
  localparam logic [4:0] SEL_CH5 = 5'b10000;

endpackage

// File: rtl/sel_encoder_16x4_onehot_enc16.sv
// Combinational 16-bit one-hot encoder.
// Ports:
//   i_vec       - 16-bit word, one-hot expected
//   o_index     - position of the lowest set bit (0 when i_vec is zero)
//   o_is_onehot - exactly one bit of i_vec is set
module onehot_enc16 (
  input  logic [15:0] i_vec,
  output logic [3:0]  o_index,
  output logic        o_is_onehot
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    o_index = 4'h0;
    for (int i = 15; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_index = 4'(i);
      end
    end
  end

  // Non-zero with no second bit: clearing the lowest set bit leaves nothing.
  assign o_is_onehot = (i_vec != 16'h0000) && ((i_vec & (i_vec - 16'h0001)) == 16'h0000);

endmodule

// File: rtl/sel_encoder_16x4.sv
// Registered one-hot to index encoder with matching mux select output.
// A single holding register presents out_code/out_sel under valid/ready.
// Non-one-hot words put the block into a sticky error mode that drives
// ERR_SEL to the mux until err_clear, and bump a saturating error counter.
// Ports:
//   i_clk, i_rst_n   - clock, asynchronous active-low reset
//   i_in_valid/i_in_vec, o_in_ready  - input handshake and word
//   o_out_valid, i_out_ready         - output handshake
//   o_out_code, o_out_sel            - encoded index and mux select
//   i_err_clear      - one-cycle pulse leaving error mode
//   o_err, o_err_cnt - sticky error flag, saturating rejected-word count
module sel_encoder_16x4 #(
  parameter int unsigned NUM_CH    = 6,
  parameter logic [4:0]  ERR_SEL   = sel_encoder_16x4_pkg::ERR_SEL,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_in_valid,
  input  logic [15:0]          i_in_vec,
  output logic                 o_in_ready,
  input  logic                 i_out_ready,
  input  logic                 i_err_clear,
  output logic                 o_out_valid,
  output logic [3:0]           o_out_code,
  output logic [4:0]           o_out_sel,
  output logic                 o_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  import sel_encoder_16x4_pkg::*;

  state_t               r_state;
  logic [3:0]           r_code;
  logic [4:0]           r_sel;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  state_t               w_state_nxt;
  logic [3:0]           w_code_nxt;
  logic [4:0]           w_sel_nxt;
  logic [ERR_CNT_W-1:0] w_err_cnt_nxt;

  logic       w_in_ready;
  logic       w_accept;
  logic [3:0] w_index;
  logic       w_is_onehot;
  logic [4:0] w_sel;

  onehot_enc16 u_enc (
    .i_vec       (i_in_vec),
    .o_index     (w_index),
    .o_is_onehot (w_is_onehot)
  );

  // Index to mux select; indices past the last channel are unmapped, not errors.
  always_comb begin
    w_sel = ERR_SEL;
    if (32'(w_index) < NUM_CH) begin
      unique case (w_index)
        4'd0:    w_sel = SEL_CH0;
        4'd1:    w_sel = SEL_CH1;
        4'd2:    w_sel = SEL_CH2;
        4'd3:    w_sel = SEL_CH3;
        4'd4:    w_sel = SEL_CH4;
        4'd5:    w_sel = SEL_CH5;
        default: w_sel = ERR_SEL;
      endcase
    end
  end

  // FULL only takes a new word when the held one drains in the same cycle.
  assign w_in_ready = (r_state == FULL) ? i_out_ready : 1'b1;
  assign w_accept   = i_in_valid & w_in_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_code_nxt    = r_code;
    w_sel_nxt     = r_sel;
    w_err_cnt_nxt = r_err_cnt;

    if (w_accept && !w_is_onehot) begin
      // A rejected word always wins, including over a simultaneous err_clear.
      w_state_nxt = ERROR;
      w_code_nxt  = 4'hF;
      w_sel_nxt   = ERR_SEL;
      if (r_err_cnt != {ERR_CNT_W{1'b1}}) begin
        w_err_cnt_nxt = r_err_cnt + 1'b1;
      end
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_state_nxt = FULL;
            w_code_nxt  = w_index;
            w_sel_nxt   = w_sel;
          end
        end
        FULL: begin
          if (w_accept) begin
            w_code_nxt = w_index;
            w_sel_nxt  = w_sel;
          end else if (i_out_ready) begin
            w_state_nxt = EMPTY;
          end
        end
        ERROR: begin
          // Valid words accepted here are discarded.
          if (i_err_clear) begin
            w_state_nxt = EMPTY;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= EMPTY;
      r_code    <= 4'h0;
      r_sel     <= 5'b00000;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_code    <= w_code_nxt;
      r_sel     <= w_sel_nxt;
      r_err_cnt <= w_err_cnt_nxt;
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = (r_state != EMPTY);
  assign o_out_code  = r_code;
  assign o_out_sel   = r_sel;
  assign o_err       = (r_state == ERROR);
  assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_sel_encoder_16x4.sv
module tb_sel_encoder_16x4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_vec;
  logic        in_ready;
  logic        out_ready;
  logic        err_clear;
  logic        out_valid;
  logic [3:0]  out_code;
  logic [4:0]  out_sel;
  logic        err;
  logic [7:0]  err_cnt;

  int checks   = 0;
  int failures = 0;

  sel_encoder_16x4 dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .i_in_vec    (in_vec),
    .o_in_ready  (in_ready),
    .i_out_ready (out_ready),
    .i_err_clear (err_clear),
    .o_out_valid (out_valid),
    .o_out_code  (out_code),
    .o_out_sel   (out_sel),
    .o_err       (err),
    .o_err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected observation after each clock edge.
  typedef struct {
    logic       v;
    logic [3:0] code;
    logic [4:0] sel;
    logic       e;
    logic [7:0] cnt;
  } obs_t;

  typedef struct {
    logic [3:0] code;
    logic [4:0] sel;
  } item_t;

  obs_t  sb[$];
  item_t held[$];  // output buffer of the model, at most one item
  bit    m_err;
  int    m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic item_t encode(input logic [15:0] vec);
    item_t it;
    int idx = 0;
    for (int i = 0; i < 16; i++) begin
      if (vec == 16'(1 << i)) idx = i;
    end
    it.code = 4'(idx);
    if (idx == 0)     it.sel = 5'b00000;
    else if (idx < 6) it.sel = 5'(1 << (idx - 1));
    else              it.sel = 5'b11111;
    return it;
  endfunction

  function automatic bit model_ready(input bit ordy);
    return m_err || (held.size() == 0) || ordy;
  endfunction

  task automatic model_reset();
    held.delete();
    sb.delete();
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_step();
    obs_t o;
    bit acc;
    acc = in_valid && model_ready(out_ready);
    if (acc && ($countones(in_vec) != 1)) begin
      m_err = 1'b1;
      held.delete();
      if (m_cnt < 255) m_cnt++;
    end else if (m_err) begin
      if (err_clear) m_err = 1'b0;
    end else begin
      if (held.size() > 0 && out_ready) void'(held.pop_front());
      if (acc) held.push_back(encode(in_vec));
    end
    o.v    = m_err || (held.size() > 0);
    o.e    = m_err;
    o.cnt  = 8'(m_cnt);
    o.code = m_err ? 4'hF : (held.size() > 0 ? held[0].code : 4'h0);
    o.sel  = m_err ? 5'b11111 : (held.size() > 0 ? held[0].sel : 5'b00000);
    sb.push_back(o);
  endtask

  // Model advances on every active edge out of reset.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst_n) model_step();
    end
  end

  // Monitor: compares DUT outputs against the oldest expectation.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("in_ready", 32'(in_ready), 32'(model_ready(out_ready)));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("out_valid", 32'(out_valid), 32'(e.v));
          chk("err", 32'(err), 32'(e.e));
          chk("err_cnt", 32'(err_cnt), 32'(e.cnt));
          if (e.v) begin
            chk("out_code", 32'(out_code), 32'(e.code));
            chk("out_sel", 32'(out_sel), 32'(e.sel));
          end
        end
      end
    end
  end

  task automatic step(input logic v, input logic [15:0] vec, input logic ordy, input logic clr);
    in_valid  = v;
    in_vec    = vec;
    out_ready = ordy;
    err_clear = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] rv;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = 16'h0;
    out_ready = 1'b0;
    err_clear = 1'b0;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_code", 32'(out_code), 32'd0);
    chk("rst_sel", 32'(out_sel), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cnt", 32'(err_cnt), 32'd0);
    #10 rst_n = 1'b1;

    // Single word
    step(1'b1, 16'h0001, 1'b1, 1'b0);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_code", 32'(out_code), 32'd0);
    chk("t1_sel", 32'(out_sel), 32'd0);
    chk("t1_err", 32'(err), 32'd0);

    // Back-to-back stream
    step(1'b1, 16'h0002, 1'b1, 1'b0);
    chk("t2_sel_a", 32'(out_sel), 32'h01);
    step(1'b1, 16'h0008, 1'b1, 1'b0);
    chk("t2_sel_b", 32'(out_sel), 32'h04);
    step(1'b1, 16'h0020, 1'b1, 1'b0);
    chk("t2_sel_c", 32'(out_sel), 32'h10);

    // Unmapped channel then stall
    step(1'b1, 16'h8000, 1'b1, 1'b0);
    chk("t3_code", 32'(out_code), 32'hF);
    chk("t3_sel", 32'(out_sel), 32'h1F);
    chk("t3_err", 32'(err), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'h0001, 1'b0, 1'b0);
      chk("t3_hold_code", 32'(out_code), 32'hF);
      chk("t3_hold_ready", 32'(in_ready), 32'd0);
    end

    // Error entry, counting, clear
    step(1'b1, 16'h0003, 1'b1, 1'b0);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_sel", 32'(out_sel), 32'h1F);
    chk("t4_cnt", 32'(err_cnt), 32'd1);
    step(1'b1, 16'h0000, 1'b1, 1'b0);
    chk("t4_cnt2", 32'(err_cnt), 32'd2);
    step(1'b0, 16'h0000, 1'b1, 1'b1);
    chk("t4_clr_valid", 32'(out_valid), 32'd0);
    chk("t4_clr_err", 32'(err), 32'd0);

    // Clear colliding with an error word, then saturation
    step(1'b1, 16'h0000, 1'b1, 1'b0);
    step(1'b1, 16'h0000, 1'b1, 1'b1);
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_cnt", 32'(err_cnt), 32'd4);
    for (int i = 0; i < 300; i++) step(1'b1, 16'h0000, 1'b1, 1'b0);
    chk("t5_sat", 32'(err_cnt), 32'hFF);
    step(1'b0, 16'h0000, 1'b1, 1'b1);

    // Asynchronous reset while stalled in FULL
    step(1'b1, 16'h0004, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(1'b1, 16'h0010, 1'b1, 1'b0);
    chk("t6_sel", 32'(out_sel), 32'h08);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       rv = 16'h0000;
        1, 2:    rv = 16'($urandom);
        default: rv = 16'(1 << $urandom_range(0, 15));
      endcase
      step(($urandom_range(0, 3) != 0), rv, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0));
    end
    step(1'b0, 16'h0000, 1'b1, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
